// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 register file slice: default widths,
// register count, the register-index type and a constant clog2 helper.
package cr16_pkg;

   localparam int WIDTH_DEF   = 16;
   localparam int REGBITS_DEF = 4;
   localparam int NUM_REGS    = 1 << REGBITS_DEF;

   typedef logic [REGBITS_DEF-1:0] reg_idx_t;

   // Ceiling log2, usable in constant expressions; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

endpackage

// File: rtl/cr16_regfile_sb_if.sv
// Bundle of decode, writeback, load-issue/return and read-port signals
// between the pipeline (master) and the register file (slave).
interface cr16_regfile_sb_if
   import cr16_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int REGBITS = REGBITS_DEF
);

   logic               wr_en;
   logic [REGBITS-1:0] wr_dst;
   logic [WIDTH-1:0]   wr_data;
   logic               jal_en;
   logic [REGBITS-1:0] jal_dst;
   logic [WIDTH-1:0]   jal_addr;
   logic               ld_issue;
   logic [REGBITS-1:0] ld_dst;
   logic               ld_ret_valid;
   logic [WIDTH-1:0]   ld_ret_data;
   logic [REGBITS-1:0] rd_a_sel;
   logic [REGBITS-1:0] rd_b_sel;
   logic [WIDTH-1:0]   rd_a_data;
   logic [WIDTH-1:0]   rd_b_data;
   logic               rd_a_busy;
   logic               rd_b_busy;
   logic               ld_full;
   logic               err;

   modport master (
      output wr_en, wr_dst, wr_data, jal_en, jal_dst, jal_addr,
             ld_issue, ld_dst, ld_ret_valid, ld_ret_data, rd_a_sel, rd_b_sel,
      input  rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, ld_full, err
   );

   modport slave (
      input  wr_en, wr_dst, wr_data, jal_en, jal_dst, jal_addr,
             ld_issue, ld_dst, ld_ret_valid, ld_ret_data, rd_a_sel, rd_b_sel,
      output rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, ld_full, err
   );

endinterface

// File: rtl/cr16_regfile_sb_ld_dst_fifo.sv
// In-order FIFO of outstanding load destinations. Circular buffer with
// wrapping pointers and an occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module ld_dst_fifo
   import cr16_pkg::*;
#(
   parameter int LD_DEPTH = 4,
   parameter int REGBITS  = REGBITS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [REGBITS-1:0] din,
   output logic [REGBITS-1:0] head,
   output logic               full,
   output logic               empty,
   output logic               err_push,
   output logic               err_pop
);

   localparam int PW = clog2(LD_DEPTH);
   localparam int CW = clog2(LD_DEPTH + 1);

   logic [REGBITS-1:0] mem [LD_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               push_ok;
   logic               pop_ok;

   assign full     = (count == CW'(LD_DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign err_pop  = pop && empty;
   assign err_push = push && full && !pop_ok;
   assign head     = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap since LD_DEPTH is a power of 2.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Destination storage.
   // NOTE: storage is not reset; occupancy gates every use, so stale slots are never observed.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cr16_regfile_sb.sv
// CR16 register file with load scoreboard. r0 reads as zero, ALU beats JAL,
// and ALU/JAL beat a same-register load return. Per-register counters track
// outstanding loads for hazard detection. Optional macro REGFILE_BYPASS_EN
// forwards same-cycle write data (ALU, then JAL, then load) to the read ports.
module cr16_regfile_sb
   import cr16_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int REGBITS  = REGBITS_DEF,
   parameter int LD_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   cr16_regfile_sb_if.slave  bus
);

   localparam int NREGS = 1 << REGBITS;
   localparam int CW    = clog2(LD_DEPTH + 1);

   logic [WIDTH-1:0]   regs     [NREGS];
   logic [CW-1:0]      busy_cnt [NREGS];
   logic [NREGS-1:0]   inc_vec;
   logic [NREGS-1:0]   dec_vec;
   logic [REGBITS-1:0] head;
   logic               full;
   logic               empty;
   logic               err_push;
   logic               err_pop;
   logic               push_ok;
   logic               pop_ok;
   logic               err_q;
   logic               aj_en;
   logic [REGBITS-1:0] aj_dst;
   logic [WIDTH-1:0]   aj_data;
   logic [REGBITS-1:0] rd_sel  [2];
   logic [WIDTH-1:0]   rd_data [2];
   logic               rd_busy [2];

   ld_dst_fifo #(
      .LD_DEPTH (LD_DEPTH),
      .REGBITS  (REGBITS)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (bus.ld_issue),
      .pop      (bus.ld_ret_valid),
      .din      (bus.ld_dst),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .err_push (err_push),
      .err_pop  (err_pop)
   );

   assign pop_ok  = bus.ld_ret_valid && !empty;
   assign push_ok = bus.ld_issue && !err_push;

   // ALU wins over JAL; the merged write then wins over a load return.
   assign aj_en   = bus.wr_en || bus.jal_en;
   assign aj_dst  = bus.wr_en ? bus.wr_dst  : bus.jal_dst;
   assign aj_data = bus.wr_en ? bus.wr_data : bus.jal_addr;

   // Per-register issue/retire strobes for the scoreboard.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (push_ok) inc_vec[bus.ld_dst] = 1'b1;
      if (pop_ok)  dec_vec[head]       = 1'b1;
   end

   // Register array writeback; r0 is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (aj_en && aj_dst == REGBITS'(i))     regs[i] <= aj_data;
            else if (pop_ok && head == REGBITS'(i)) regs[i] <= bus.ld_ret_data;
         end
      end
   end

   // Outstanding-load counters; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) busy_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (inc_vec[i] && !dec_vec[i])      busy_cnt[i] <= busy_cnt[i] + CW'(1);
            else if (dec_vec[i] && !inc_vec[i]) busy_cnt[i] <= busy_cnt[i] - CW'(1);
         end
      end
   end

   // Sticky protocol error: overflowing issue or return with nothing pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_q | err_push | err_pop;
   end

   assign rd_sel[0] = bus.rd_a_sel;
   assign rd_sel[1] = bus.rd_b_sel;

   // Combinational read ports, with optional same-cycle forwarding.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (rd_sel[p] != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (aj_en && aj_dst == rd_sel[p])       rd_data[p] = aj_data;
            else if (pop_ok && head == rd_sel[p])   rd_data[p] = bus.ld_ret_data;
            else                                    rd_data[p] = regs[rd_sel[p]];
            rd_busy[p] = (busy_cnt[rd_sel[p]] != '0) &&
                         !(dec_vec[rd_sel[p]] && !inc_vec[rd_sel[p]] &&
                           busy_cnt[rd_sel[p]] == CW'(1));
`else
            rd_data[p] = regs[rd_sel[p]];
            rd_busy[p] = (busy_cnt[rd_sel[p]] != '0);
`endif
         end
      end
   end

   assign bus.rd_a_data = rd_data[0];
   assign bus.rd_b_data = rd_data[1];
   assign bus.rd_a_busy = rd_busy[0];
   assign bus.rd_b_busy = rd_busy[1];
   assign bus.ld_full   = full;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_cr16_regfile_sb.sv
// Scoreboard bench for cr16_regfile_sb: stimulus updates a queue-based
// reference model and pushes expected read-port state; a negedge monitor
// pops and compares against the DUT.
module tb_cr16_regfile_sb;
   import cr16_pkg::*;

   localparam int WIDTH    = 16;
   localparam int REGBITS  = 4;
   localparam int LD_DEPTH = 4;

   typedef struct {
      bit wr_en;    int wr_dst;  int wr_data;
      bit jal_en;   int jal_dst; int jal_addr;
      bit ld_issue; int ld_dst;
      bit ret_valid; int ret_data;
   } stim_t;

   typedef struct {
      int tag;
      int a_data; bit a_busy;
      int b_data; bit b_busy;
      bit full;   bit err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   cr16_regfile_sb_if #(.WIDTH(WIDTH), .REGBITS(REGBITS)) bus ();

   cr16_regfile_sb #(
      .WIDTH    (WIDTH),
      .REGBITS  (REGBITS),
      .LD_DEPTH (LD_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   tests   = 0;
   int   fails   = 0;
   int   tag_cnt = 0;

   // Reference model: register values, in-order list of pending load targets, error flag.
   int m_regs[NUM_REGS];
   int m_ld[$];
   bit m_err;

   function automatic void model_reset();
      foreach (m_regs[i]) m_regs[i] = 0;
      m_ld.delete();
      m_err = 1'b0;
   endfunction

   function automatic int pending(int r);
      int n = 0;
      foreach (m_ld[i]) if (m_ld[i] == r) n++;
      return n;
   endfunction

   function automatic void model_apply(stim_t s);
      bit full_pre = (m_ld.size() == LD_DEPTH);
      bit popped   = 1'b0;
      int hd;
      if (s.ret_valid) begin
         if (m_ld.size() == 0) m_err = 1'b1;
         else begin
            hd = m_ld.pop_front();
            popped = 1'b1;
            if (hd != 0) m_regs[hd] = s.ret_data;
         end
      end
      if (s.ld_issue) begin
         if (full_pre && !popped) m_err = 1'b1;
         else m_ld.push_back(s.ld_dst);
      end
      if (s.wr_en) begin
         if (s.wr_dst != 0) m_regs[s.wr_dst] = s.wr_data;
      end else if (s.jal_en && s.jal_dst != 0) begin
         m_regs[s.jal_dst] = s.jal_addr;
      end
   endfunction

   function automatic exp_t model_expect(int sa, int sb);
      exp_t e;
      tag_cnt++;
      e.tag    = tag_cnt;
      e.a_data = (sa == 0) ? 0 : m_regs[sa];
      e.a_busy = (sa != 0) && (pending(sa) > 0);
      e.b_data = (sb == 0) ? 0 : m_regs[sb];
      e.b_busy = (sb != 0) && (pending(sb) > 0);
      e.full   = (m_ld.size() == LD_DEPTH);
      e.err    = m_err;
      return e;
   endfunction

   task automatic check(string name, int tag, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (check %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s = '{default: 0};
      return s;
   endfunction

   task automatic drive(stim_t s);
      bus.wr_en        = s.wr_en;
      bus.wr_dst       = REGBITS'(s.wr_dst);
      bus.wr_data      = WIDTH'(s.wr_data);
      bus.jal_en       = s.jal_en;
      bus.jal_dst      = REGBITS'(s.jal_dst);
      bus.jal_addr     = WIDTH'(s.jal_addr);
      bus.ld_issue     = s.ld_issue;
      bus.ld_dst       = REGBITS'(s.ld_dst);
      bus.ld_ret_valid = s.ret_valid;
      bus.ld_ret_data  = WIDTH'(s.ret_data);
   endtask

   task automatic step(stim_t s);
      drive(s);
      @(posedge clk);
      model_apply(s);
      #1;
      drive(idle_stim());
   endtask

   task automatic look(int sa, int sb);
      bus.rd_a_sel = REGBITS'(sa);
      bus.rd_b_sel = REGBITS'(sb);
      exp_q.push_back(model_expect(sa, sb));
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int dst, int data);
      stim_t s = idle_stim();
      s.wr_en = 1; s.wr_dst = dst; s.wr_data = data;
      step(s);
   endtask

   task automatic issue(int dst);
      stim_t s = idle_stim();
      s.ld_issue = 1; s.ld_dst = dst;
      step(s);
   endtask

   task automatic ret(int data);
      stim_t s = idle_stim();
      s.ret_valid = 1; s.ret_data = data;
      step(s);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compares the oldest expectation against the DUT mid-cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_a_data", e.tag, 32'(bus.rd_a_data), e.a_data);
         check("rd_a_busy", e.tag, 32'(bus.rd_a_busy), 32'(e.a_busy));
         check("rd_b_data", e.tag, 32'(bus.rd_b_data), e.b_data);
         check("rd_b_busy", e.tag, 32'(bus.rd_b_busy), 32'(e.b_busy));
         check("ld_full",   e.tag, 32'(bus.ld_full),   32'(e.full));
         check("err",       e.tag, 32'(bus.err),       32'(e.err));
      end
   end

   initial begin
      stim_t s;
      exp_t  e;
      int    guard;

      drive(idle_stim());
      bus.rd_a_sel = '0;
      bus.rd_b_sel = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state and r0, then reset in the middle of activity.
      look(0, 5);
      wr(3, 16'h1234);
      issue(6);
      issue(8);
      look(3, 6);
      reset = 1'b1;
      model_reset();
      look(3, 6);
      look(8, 0);
      reset = 1'b0;
      wr(0, 16'hFFFF);
      look(0, 3);

      // ALU beats JAL to the same register.
      s = idle_stim();
      s.wr_en = 1;  s.wr_dst = 5;  s.wr_data = 16'hAAAA;
      s.jal_en = 1; s.jal_dst = 5; s.jal_addr = 16'h0042;
      step(s);
      look(5, 0);

      // Scoreboard with two loads pending to the same register.
      issue(2);
      issue(2);
      issue(7);
      look(2, 7);
      ret(16'h1111);
      look(2, 7);
      ret(16'h2222);
      look(2, 7);
      ret(16'h3333);
      look(7, 2);

      // FIFO full, overflow ignored, drain in order.
      for (int i = 1; i <= 4; i++) issue(i);
      look(1, 4);
      issue(9);
      look(9, 1);
      for (int i = 1; i <= 4; i++) ret(16'hA000 + i);
      look(1, 2);
      look(3, 4);
      look(9, 0);

      // Issue with return at full keeps occupancy; return on empty is an error.
      do_reset();
      for (int i = 1; i <= 4; i++) issue(i);
      s = idle_stim();
      s.ld_issue = 1; s.ld_dst = 5; s.ret_valid = 1; s.ret_data = 16'hB001;
      step(s);
      look(1, 5);
      for (int i = 0; i < 4; i++) ret(16'hB100 + i);
      look(5, 2);
      s = idle_stim();
      s.ld_issue = 1; s.ld_dst = 6; s.ret_valid = 1; s.ret_data = 16'hDEAD;
      step(s);
      look(6, 0);

      // Pointer wrap-around through ten issue/return pairs.
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         issue(i);
         ret(16'h0100 + i);
      end
      for (int i = 1; i <= 10; i += 2) look(i, i + 1);

      // ALU write and load return colliding on r4.
      wr(4, 16'h5555);
      issue(4);
      look(4, 0);
      s = idle_stim();
      s.wr_en = 1; s.wr_dst = 4; s.wr_data = 16'hBEEF;
      s.ret_valid = 1; s.ret_data = 16'hDEAD;
      drive(s);
      bus.rd_a_sel = 4'd4;
      bus.rd_b_sel = 4'd0;
      e = model_expect(4, 0);
`ifdef REGFILE_BYPASS_EN
      e.a_data = 16'hBEEF;
      e.a_busy = 1'b0;
`endif
      exp_q.push_back(e);
      @(posedge clk);
      model_apply(s);
      #1;
      drive(idle_stim());
      look(4, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 300; n++) begin
         s = idle_stim();
         s.wr_en    = ($urandom_range(0, 9) < 4);
         s.wr_dst   = $urandom_range(0, 15);
         s.wr_data  = $urandom_range(0, 16'hFFFF);
         s.jal_en   = ($urandom_range(0, 9) < 2);
         s.jal_dst  = $urandom_range(0, 15);
         s.jal_addr = $urandom_range(0, 16'hFFFF);
         s.ld_issue = ($urandom_range(0, 9) < 4);
         s.ld_dst   = $urandom_range(0, 15);
         s.ret_valid = (m_ld.size() > 0) ? ($urandom_range(0, 9) < 4)
                                         : ($urandom_range(0, 19) == 0);
         s.ret_data = $urandom_range(0, 16'hFFFF);
         step(s);
         look($urandom_range(0, 15), $urandom_range(0, 15));
      end

      // Let the monitor drain, bounded.
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("monitor_drained", 0, 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
